// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM and auto-repeat
// timer producing a clean level plus one-cycle press/release/repeat/up pulses.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int CNT_W           = 26
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic up_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        REPEAT,
        DEB_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic             s0;
    logic             s1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= btn_in;
            s1 <= s0;
        end
    end

    // Pulses default low every cycle so each one lasts exactly one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            timer         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            up_pulse      <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            up_pulse      <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (s1) state <= DEB_PRESS;
                end
                DEB_PRESS: begin
                    if (!s1) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == DEB_LAST) begin
                        state       <= PRESSED;
                        timer       <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                        up_pulse    <= 1'b1;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                PRESSED: begin
                    if (!s1) begin
                        state <= DEB_RELEASE;
                        timer <= '0;
                    end else if (!repeat_en) begin
                        timer <= '0;
                    end else if (timer == DELAY_LAST) begin
                        state        <= REPEAT;
                        timer        <= '0;
                        repeat_pulse <= 1'b1;
                        up_pulse     <= 1'b1;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                REPEAT: begin
                    if (!s1) begin
                        state <= DEB_RELEASE;
                        timer <= '0;
                    end else if (!repeat_en) begin
                        state <= PRESSED;
                        timer <= '0;
                    end else if (timer == RATE_LAST) begin
                        timer        <= '0;
                        repeat_pulse <= 1'b1;
                        up_pulse     <= 1'b1;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                DEB_RELEASE: begin
                    // A bounce back high restarts the repeat delay from zero.
                    if (s1) begin
                        state <= PRESSED;
                        timer <= '0;
                    end else if (timer == DEB_LAST) begin
                        state         <= IDLE;
                        timer         <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// checked against an event-level reference model through an expected-pulse queue.
module tb_button_conditioner;

    localparam int DEB   = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 3;
    localparam int W     = 36;

    logic clock;
    logic reset;
    logic btn_in;
    logic repeat_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic up_pulse;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_RATE    (RATE),
        .CNT_W          (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_in       (btn_in),
        .repeat_en    (repeat_en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .up_pulse     (up_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected entries: {edge number, press, release, repeat, up}.
    logic [W-1:0] exp_q[$];
    int tests  = 0;
    int failed = 0;
    int edge_n = 0;
    int up_seen = 0;
    int rel_seen = 0;
    logic prev_up = 1'b0;

    // Reference model: samples seen after the 2-cycle synchronizer delay,
    // the accepted level, a run length of disagreeing samples, and hold age.
    logic delay_q[$];
    logic m_level;
    int   run;
    int   age;

    task automatic model_clear();
        delay_q = {1'b0, 1'b0};
        m_level = 1'b0;
        run = 0;
        age = 0;
    endtask

    task automatic model_step();
        logic s, pr, rl, rp;
        edge_n++;
        pr = 1'b0; rl = 1'b0; rp = 1'b0;
        if (reset) begin
            model_clear();
            return;
        end
        s = delay_q.pop_front();
        delay_q.push_back(btn_in);
        if (s != m_level) begin
            run++;
            if (run == DEB + 1) begin
                run = 0;
                age = 0;
                m_level = s;
                if (s) pr = 1'b1; else rl = 1'b1;
            end
        end else if (run != 0) begin
            run = 0;
            age = 0;
        end else if (m_level) begin
            if (repeat_en) begin
                age++;
                if (age >= DELAY && (age - DELAY) % RATE == 0) rp = 1'b1;
            end else begin
                age = 0;
            end
        end
        if (pr | rl | rp) exp_q.push_back({32'(edge_n), pr, rl, rp, pr | rp});
    endtask

    task automatic cycle(input logic b, input logic en);
        @(posedge clock);
        model_step();
        #2;
        btn_in = b;
        repeat_en = en;
    endtask

    task automatic hold(input logic b, input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(b, en);
    endtask

    // Asserted between edges: any pulse registered at the last edge is dropped.
    task automatic do_reset(input int n);
        reset = 1'b1;
        model_clear();
        while (exp_q.size() > 0 && exp_q[$][W-1:4] == 32'(edge_n)) void'(exp_q.pop_back());
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_step();
            #2;
        end
        reset = 1'b0;
    endtask

    task automatic check_count(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    always @(negedge clock) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {32'(edge_n), press_pulse, release_pulse, repeat_pulse, up_pulse};
        tests++;
        if (btn_level !== m_level) begin
            failed++;
            $display("FAIL btn_level edge %0d: got %b expected %b", edge_n, btn_level, m_level);
        end
        if (exp_q.size() > 0 && exp_q[0][W-1:4] == 32'(edge_n)) want = exp_q.pop_front();
        else want = {32'(edge_n), 4'b0000};
        if (got[3:0] != 4'b0000 || want[3:0] != 4'b0000) begin
            tests++;
            if (got !== want) begin
                failed++;
                $display("FAIL pulses edge %0d: got prs/rel/rep/up=%b expected %b",
                         edge_n, got[3:0], want[3:0]);
            end
        end
        if (up_pulse) begin
            tests++;
            up_seen++;
            if (prev_up) begin
                failed++;
                $display("FAIL up_adjacent edge %0d: got two consecutive up pulses expected one", edge_n);
            end
        end
        if (release_pulse) rel_seen++;
        prev_up = up_pulse;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int up0, rel0, len, kind;
        logic b, en;
        model_clear();
        reset = 1'b1;
        btn_in = 1'b0;
        repeat_en = 1'b1;
        hold(1'b0, 1'b1, 3);
        reset = 1'b0;
        hold(1'b0, 1'b1, 5);

        // Clean press with auto-repeat: 1 press + 7 repeats, then one release.
        up0 = up_seen; rel0 = rel_seen;
        hold(1'b1, 1'b1, 35);
        hold(1'b0, 1'b1, 15);
        check_count("repeat_up_count", up_seen - up0, 8);
        check_count("repeat_release_count", rel_seen - rel0, 1);

        // Short bounces never pass the debouncer.
        up0 = up_seen; rel0 = rel_seen;
        for (int i = 0; i < 2; i++) begin
            hold(1'b1, 1'b1, 2);
            hold(1'b0, 1'b1, 2);
        end
        hold(1'b0, 1'b1, 20);
        check_count("bounce_up_count", up_seen - up0, 0);
        check_count("bounce_release_count", rel_seen - rel0, 0);

        // repeat_en low: single up pulse for a long hold.
        up0 = up_seen; rel0 = rel_seen;
        hold(1'b1, 1'b0, 40);
        hold(1'b0, 1'b0, 15);
        check_count("norepeat_up_count", up_seen - up0, 1);
        check_count("norepeat_release_count", rel_seen - rel0, 1);

        // Release bounce while pressed.
        rel0 = rel_seen;
        hold(1'b1, 1'b1, 12);
        hold(1'b0, 1'b1, 2);
        hold(1'b1, 1'b1, 20);
        check_count("release_bounce_count", rel_seen - rel0, 0);
        hold(1'b0, 1'b1, 15);

        // Reset in the middle of a press, button still held afterwards.
        up0 = up_seen;
        hold(1'b1, 1'b0, 4);
        do_reset(3);
        hold(1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 15);
        check_count("reset_press_count", up_seen - up0, 1);

        // Random activity: segments of random length and level, random
        // repeat_en flips, and occasional resets.
        en = 1'b1;
        for (int seg = 0; seg < 250; seg++) begin
            kind = int'($urandom_range(0, 19));
            if (kind == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                if (kind < 8) len = int'($urandom_range(1, 5));
                else len = int'($urandom_range(6, 40));
                b = ~btn_in;
                for (int i = 0; i < len; i++) begin
                    if ($urandom_range(0, 15) == 0) en = ~en;
                    cycle(b, en);
                end
            end
        end
        hold(1'b0, 1'b1, 40);
        check_count("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream stage of the two-digit BCD up-counter/7-seg display block.
- Turns a raw, bouncy, asynchronous push-button into a clean debounced level plus single-cycle press, release and auto-repeat pulses.
- up_pulse drives the counter's up input directly.
- Pulses are one cycle wide and never adjacent, so the counter's own 0->1 edge detector sees each one.

Parameters:
DEBOUNCE_CYCLES, 1000000, stable-sample cycles needed to accept a level change (10 ms at 100 MHz); must be >=2
REPEAT_DELAY, 50000000, hold cycles after the accepted press before the first auto-repeat (0.5 s); must be >=2
REPEAT_RATE, 10000000, cycles between later auto-repeats (0.1 s); must be >=2
CNT_W, 26, timer width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)-1

Ports:
clock  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
btn_in  input  1  raw button, asynchronous, active-high
repeat_en  input  1  1 = auto-repeat while held; sampled every cycle
btn_level  output  1  debounced button level
press_pulse  output  1  one-cycle pulse on an accepted press
release_pulse  output  1  one-cycle pulse on an accepted release
repeat_pulse  output  1  one-cycle pulse on each auto-repeat
up_pulse  output  1  press_pulse OR repeat_pulse; registered

Behaviour:
- Reset: sync flops, timer and all outputs go to 0; state goes to IDLE. There is no pulse on reset release.
- Synchronizer: btn_in passes through two flops (s0 -> s1), giving 2 cycles of latency. Only s1 is used downstream.
- Single CNT_W timer, cleared on every state change. All outputs are registered.
- IDLE (btn_level=0): s1=1 -> DEB_PRESS.
- DEB_PRESS (btn_level=0):
  - s1=0 -> IDLE. This is a bounce and produces no pulse.
  - timer==DEBOUNCE_CYCLES-1 with s1=1 -> PRESSED. Assert press_pulse, up_pulse and btn_level at this edge.
  - Otherwise the timer increments.
- PRESSED (btn_level=1):
  - s1=0 -> DEB_RELEASE. This has priority.
  - repeat_en=1 and timer==REPEAT_DELAY-1 -> REPEAT. Assert repeat_pulse and up_pulse.
  - repeat_en=0: the timer holds at 0.
- REPEAT (btn_level=1):
  - s1=0 -> DEB_RELEASE.
  - repeat_en=0 -> PRESSED, with the timer held at 0.
  - timer==REPEAT_RATE-1: assert repeat_pulse and up_pulse, clear the timer, stay in REPEAT.
- DEB_RELEASE (btn_level stays 1):
  - s1=1 -> PRESSED. The bounce is rejected and the repeat delay restarts from 0.
  - timer==DEBOUNCE_CYCLES-1 with s1=0 -> IDLE. Assert release_pulse and clear btn_level at this edge.
- Latency: btn_in first sampled 1 at edge 1 and held stable. press_pulse is then registered at edge DEBOUNCE_CYCLES+3 and is high for exactly one cycle. Release is symmetric.
- Pulse rules:
  - Every pulse lasts exactly 1 cycle.
  - press_pulse and repeat_pulse never coincide.
  - up_pulse is never high on two consecutive cycles, because all intervals are >=2.
- Counts:
  - An accepted press gives exactly one press_pulse.
  - A hold with repeat_en=1 gives N repeats, where N = floor((hold_cycles - REPEAT_DELAY)/REPEAT_RATE)+1 once hold_cycles >= REPEAT_DELAY.
  - Releasing gives exactly one release_pulse.
- Glitches shorter than DEBOUNCE_CYCLES in either direction produce no pulse and no btn_level change.
- Reset mid-operation: everything returns to IDLE immediately and any in-flight pulse is dropped. If the button is still held after reset deasserts, it is re-debounced and one press_pulse is produced DEBOUNCE_CYCLES+3 edges later.
- Timers never wrap. Each compare-equal clears or changes state before overflow.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, CNT_W=4 for all scenarios.
1. Clean press: btn_in 0->1 before edge 1, held -> press_pulse=up_pulse=1 for the cycle after edge 7 only; btn_level=1 from edge 7; no other pulses before edge 17.
2. Bounce: btn_in toggles 1,0,1,0 every 2 cycles, then stays 0 for 20 cycles -> no pulses, btn_level stays 0.
3. Auto-repeat: hold for 30 cycles after the press at edge 7 -> repeat_pulse at edges 17, 20, 23, 26, 29, 32, 35; up_pulse high 8 times in total; never two consecutive cycles.
4. repeat_en=0 held for 40 cycles -> exactly one up_pulse. Release -> release_pulse exactly DEBOUNCE_CYCLES+3 edges after btn_in falls; btn_level drops on the same edge.
5. Release bounce: while PRESSED, btn_in low for 2 cycles then high -> no release_pulse; first repeat 10 edges after the return to PRESSED.
6. Reset at edge 5 of a press with btn_in held, deasserted at edge 8 -> all outputs 0 during reset; single press_pulse at 7 edges after reset deassertion.
